mem_bus_sched: RTL

MEM_BUS_SCHED -- requirements
Module: mem_bus_sched

---
 rtl/mem_bus_sched_pkg.sv | 11 +
 rtl/mem_bus_grant.sv | 17 +
 rtl/mem_bus_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_bus_sched_pkg.sv
// mem_bus_sched_pkg: shared states, requester ids, length codes and widths for mem_bus_sched.
package mem_bus_sched_pkg;
  localparam int AddrLen = 32;
  localparam int RegLen = 32;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {REQ_D, REQ_IF} req_t;
  localparam logic [2:0] LEN1 = 3'd1, LEN2 = 3'd2, LEN4 = 3'd4;
  function automatic logic [2:0] norm_len(input logic [2:0] l);
    return (l == LEN1 || l == LEN2) ? l : LEN4;
  endfunction
endpackage

// File: rtl/mem_bus_grant.sv
// mem_bus_grant: picks fetch or data requester; round-robin under MEM_BUS_SCHED_RR_EN, else data always wins.
module mem_bus_grant import mem_bus_sched_pkg::*; (
`ifdef MEM_BUS_SCHED_RR_EN
  input  req_t last,
`endif
  input  logic if_req,
  input  logic d_req,
  output logic gnt,
  output req_t gnt_id
);
  assign gnt = if_req | d_req;
`ifdef MEM_BUS_SCHED_RR_EN
  assign gnt_id = (if_req && !(d_req && last == REQ_IF)) ? REQ_IF : REQ_D;
`else
  assign gnt_id = d_req ? REQ_D : REQ_IF;
`endif
endmodule

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: byte-serial memory bus scheduler shared by an instruction-fetch and a data port.
// Define MEM_BUS_SCHED_RR_EN for round-robin arbitration; default is fixed data-first priority.
module mem_bus_sched import mem_bus_sched_pkg::*; #(
  parameter int ADDR_W = AddrLen
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_len,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_wr
);
  state_t state;
  req_t who, gnt_id;
  logic gnt, is_wr, wr_q, if_done_q, d_done_q;
  logic [ADDR_W-1:0] base, sel_a;
  logic [2:0] len, cnt;
  logic [RegLen-1:0] wbuf, rbuf, rnext;
`ifdef MEM_BUS_SCHED_RR_EN
  req_t last;
`endif
  mem_bus_grant u_grant (
`ifdef MEM_BUS_SCHED_RR_EN
    .last(last),
`endif
    .if_req(if_req && !if_flush),
    .d_req(d_req),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  assign is_wr = gnt_id == REQ_D && d_we;
  assign sel_a = gnt_id == REQ_IF ? if_addr : d_addr;
  // read data trails its address by one cycle, so the byte landing now belongs to cnt-2
  assign rnext = rbuf | (RegLen'(mem_din) << {cnt[1:0] - 2'd2, 3'b000});
  assign mem_wr = wr_q & rdy;
  assign if_done = if_done_q & rdy;
  assign d_done = d_done_q & rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      who <= REQ_D;
      base <= '0;
      len <= '0;
      cnt <= '0;
      wbuf <= '0;
      rbuf <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      wr_q <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q <= 1'b0;
      if_data <= '0;
      d_rdata <= '0;
`ifdef MEM_BUS_SCHED_RR_EN
      last <= REQ_D;
`endif
    end else if (rdy) begin
      if_done_q <= 1'b0;
      d_done_q <= 1'b0;
      wr_q <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          who <= gnt_id;
          base <= sel_a;
          mem_a <= sel_a;
          len <= gnt_id == REQ_IF ? LEN4 : norm_len(d_len);
          wbuf <= d_wdata;
          rbuf <= '0;
          cnt <= 3'd1;
          wr_q <= is_wr;
          if (is_wr) mem_dout <= d_wdata[7:0];
          state <= is_wr ? WRITE : READ;
`ifdef MEM_BUS_SCHED_RR_EN
          last <= gnt_id;
`endif
        end
        READ: if (who == REQ_IF && if_flush) begin
          state <= IDLE;
          cnt <= '0;
          rbuf <= '0;
        end else begin
          if (cnt < len) mem_a <= base + ADDR_W'(cnt);
          if (cnt >= 3'd2) rbuf <= rnext;
          cnt <= cnt + 3'd1;
          if (cnt == len + 3'd1) begin
            state <= IDLE;
            cnt <= '0;
            rbuf <= '0;
            if (who == REQ_IF) if_data <= rnext;
            else d_rdata <= rnext;
            if_done_q <= who == REQ_IF;
            d_done_q <= who == REQ_D;
          end
        end
        WRITE: if (cnt < len) begin
          mem_a <= base + ADDR_W'(cnt);
          mem_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
          wr_q <= 1'b1;
          cnt <= cnt + 3'd1;
        end else begin
          state <= IDLE;
          cnt <= '0;
          d_done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
